mem_stage: RTL and testbench

//  Pipeline stage directly downstream of EX. Latches one instruction from EX per valid/ready handshake.

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_lsu_align.sv | 44 ++++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int LD_ST_INFO_WIDTH = 5;

  // ld_st_info bit offsets
  localparam int LS_LOAD     = 0;
  localparam int LS_STORE    = 1;
  localparam int LS_SIZE     = 2;  // two bits: [3:2]
  localparam int LS_UNSIGNED = 4;

  // access size encodings
  localparam logic [1:0] LS_SIZE_B = 2'b00;
  localparam logic [1:0] LS_SIZE_H = 2'b01;
  localparam logic [1:0] LS_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,  // empty, or holding a result that needed no bus access
    MEM_ST_REQ  = 2'd1,  // bus request presented, waiting for acceptance
    MEM_ST_WAIT = 2'd2,  // request accepted, waiting for response
    MEM_ST_DONE = 2'd3   // response captured, waiting for WB
  } mem_st_e;

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic ls_misalign(input logic [1:0] size, input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (size == LS_SIZE_H) m = a[0];
    else if (size == LS_SIZE_W) m = |a;
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        is_store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Lane selection is purely a function of size and the low address bits.
  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    misalign = ls_misalign(size, addr_lo);
    case (size)
      LS_SIZE_B: begin
        wdata     = {4{rs2[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        load_data = is_unsigned ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      LS_SIZE_H: begin
        wdata     = {2{rs2[15:0]}};
        wstrb     = 4'b0011 << addr_lo;
        load_data = is_unsigned ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wdata     = rs2;
        wstrb     = 4'hF;
        load_data = shifted;
      end
    endcase
    // loads never assert write strobes
    if (!is_store) wstrb = 4'h0;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: one-entry buffer between EX and WB that performs the data-bus access.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EXCP_IN_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  // from EX
  input  logic                  ex_valid_i,
  output logic                  mem_ready_o,
  input  logic [XLEN-1:0]       ex_pc_i,
  input  logic [XLEN-1:0]       ex_alu_res_i,
  input  logic [XLEN-1:0]       ex_rs2_rdata_i,
  input  logic [4:0]            ex_ld_st_info_i,
  input  logic                  ex_rd_wen_i,
  input  logic [4:0]            ex_rd_idx_i,
  input  logic [EXCP_IN_W-1:0]  ex_excp_i,
  // data bus
  output logic                  dbus_req_valid_o,
  input  logic                  dbus_req_ready_i,
  output logic                  dbus_req_we_o,
  output logic [XLEN-1:0]       dbus_req_addr_o,
  output logic [XLEN-1:0]       dbus_req_wdata_o,
  output logic [3:0]            dbus_req_wstrb_o,
  input  logic                  dbus_rsp_valid_i,
  input  logic [XLEN-1:0]       dbus_rsp_rdata_i,
  input  logic                  dbus_rsp_err_i,
  // to WB
  output logic                  mem_valid_o,
  input  logic                  wb_ready_i,
  output logic [XLEN-1:0]       mem_pc_o,
  output logic [4:0]            mem_rd_idx_o,
  output logic                  mem_rd_wen_o,
  output logic [XLEN-1:0]       mem_rd_wdata_o,
  output logic [EXCP_IN_W+1:0]  mem_excp_o
);

  mem_st_e                state_q, state_d;
  logic                   data_valid_q, data_valid_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [XLEN-1:0]        rs2_q, rs2_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [4:0]             info_q, info_d;
  logic [4:0]             rd_idx_q, rd_idx_d;
  logic                   rd_wen_q, rd_wen_d;
  logic [EXCP_IN_W-1:0]   excp_q, excp_d;
  logic                   bus_err_q, bus_err_d;

  logic        ex_is_ls, ex_misalign, go_bus, accept;
  logic        is_ls_q, al_misalign, misalign_flag;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load_data;

  // Alignment runs on the latched instruction; the bus response is consumed directly.
  mem_lsu_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (info_q[LS_SIZE +: 2]),
    .is_unsigned (info_q[LS_UNSIGNED]),
    .is_store    (info_q[LS_STORE]),
    .rs2         (rs2_q),
    .rdata       (dbus_rsp_rdata_i),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .misalign    (al_misalign),
    .load_data   (al_load_data)
  );

  // Handshake terms and the accept-time decision of whether the bus is needed.
  always_comb begin
    mem_valid_o   = data_valid_q & ((state_q == MEM_ST_IDLE) | (state_q == MEM_ST_DONE));
    mem_ready_o   = !data_valid_q | (mem_valid_o & wb_ready_i);
    accept        = mem_ready_o & ex_valid_i;
    ex_is_ls      = ex_ld_st_info_i[LS_LOAD] | ex_ld_st_info_i[LS_STORE];
    ex_misalign   = ex_is_ls & ls_misalign(ex_ld_st_info_i[LS_SIZE +: 2], ex_alu_res_i[1:0]);
    go_bus        = ex_is_ls & !ex_misalign & (ex_excp_i == '0);
    is_ls_q       = info_q[LS_LOAD] | info_q[LS_STORE];
    misalign_flag = is_ls_q & al_misalign;
  end

  // FSM next-state and stage-register update.
  always_comb begin
    state_d          = state_q;
    data_valid_d     = data_valid_q;
    pc_d             = pc_q;
    addr_d           = addr_q;
    rs2_d            = rs2_q;
    wdata_d          = wdata_q;
    info_d           = info_q;
    rd_idx_d         = rd_idx_q;
    rd_wen_d         = rd_wen_q;
    excp_d           = excp_q;
    bus_err_d        = bus_err_q;
    dbus_req_valid_o = 1'b0;
    case (state_q)
      MEM_ST_REQ: begin
        dbus_req_valid_o = 1'b1;
        if (dbus_req_ready_i) state_d = MEM_ST_WAIT;
      end
      MEM_ST_WAIT: begin
        if (dbus_rsp_valid_i) begin
          if (info_q[LS_LOAD]) wdata_d = al_load_data;
          bus_err_d = dbus_rsp_err_i;
          state_d   = MEM_ST_DONE;
        end
      end
      default: begin  // IDLE or DONE: may hand off and refill in one cycle
        if (accept) begin
          data_valid_d = 1'b1;
          pc_d         = ex_pc_i;
          addr_d       = ex_alu_res_i;
          rs2_d        = ex_rs2_rdata_i;
          wdata_d      = ex_alu_res_i;
          info_d       = ex_ld_st_info_i;
          rd_idx_d     = ex_rd_idx_i;
          rd_wen_d     = ex_rd_wen_i;
          excp_d       = ex_excp_i;
          bus_err_d    = 1'b0;
          state_d      = go_bus ? MEM_ST_REQ : MEM_ST_IDLE;
        end else if (mem_ready_o) begin
          data_valid_d = 1'b0;
          state_d      = MEM_ST_IDLE;
        end
      end
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEM_ST_IDLE;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Payload registers are don't-care while the stage is empty, so no reset.
  always_ff @(posedge clk) begin
    pc_q      <= pc_d;
    addr_q    <= addr_d;
    rs2_q     <= rs2_d;
    wdata_q   <= wdata_d;
    info_q    <= info_d;
    rd_idx_q  <= rd_idx_d;
    rd_wen_q  <= rd_wen_d;
    excp_q    <= excp_d;
    bus_err_q <= bus_err_d;
  end

  // Bus request fields and WB outputs straight from the stage registers.
  always_comb begin
    dbus_req_we_o    = info_q[LS_STORE];
    dbus_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    dbus_req_wdata_o = al_wdata;
    dbus_req_wstrb_o = al_wstrb;
    mem_pc_o         = pc_q;
    mem_rd_idx_o     = rd_idx_q;
    mem_rd_wen_o     = rd_wen_q & !misalign_flag & !bus_err_q;
    mem_rd_wdata_o   = wdata_q;
    mem_excp_o       = {bus_err_q, misalign_flag, excp_q};
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expectations, monitors pop and compare.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        mem_ready_o;
  logic [31:0] ex_pc_i = '0, ex_alu_res_i = '0, ex_rs2_rdata_i = '0;
  logic [4:0]  ex_ld_st_info_i = '0, ex_rd_idx_i = '0;
  logic        ex_rd_wen_i = 1'b0;
  logic [5:0]  ex_excp_i = '0;
  logic        dbus_req_valid_o, dbus_req_ready_i, dbus_req_we_o;
  logic [31:0] dbus_req_addr_o, dbus_req_wdata_o;
  logic [3:0]  dbus_req_wstrb_o;
  logic        dbus_rsp_valid_i, dbus_rsp_err_i;
  logic [31:0] dbus_rsp_rdata_i;
  logic        mem_valid_o, wb_ready_i = 1'b0;
  logic [31:0] mem_pc_o, mem_rd_wdata_o;
  logic [4:0]  mem_rd_idx_o;
  logic        mem_rd_wen_o;
  logic [7:0]  mem_excp_o;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .EXCP_IN_W(6)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .mem_ready_o(mem_ready_o),
    .ex_pc_i(ex_pc_i), .ex_alu_res_i(ex_alu_res_i), .ex_rs2_rdata_i(ex_rs2_rdata_i),
    .ex_ld_st_info_i(ex_ld_st_info_i), .ex_rd_wen_i(ex_rd_wen_i), .ex_rd_idx_i(ex_rd_idx_i),
    .ex_excp_i(ex_excp_i),
    .dbus_req_valid_o(dbus_req_valid_o), .dbus_req_ready_i(dbus_req_ready_i),
    .dbus_req_we_o(dbus_req_we_o), .dbus_req_addr_o(dbus_req_addr_o),
    .dbus_req_wdata_o(dbus_req_wdata_o), .dbus_req_wstrb_o(dbus_req_wstrb_o),
    .dbus_rsp_valid_i(dbus_rsp_valid_i), .dbus_rsp_rdata_i(dbus_rsp_rdata_i),
    .dbus_rsp_err_i(dbus_rsp_err_i),
    .mem_valid_o(mem_valid_o), .wb_ready_i(wb_ready_i),
    .mem_pc_o(mem_pc_o), .mem_rd_idx_o(mem_rd_idx_o), .mem_rd_wen_o(mem_rd_wen_o),
    .mem_rd_wdata_o(mem_rd_wdata_o), .mem_excp_o(mem_excp_o)
  );

  typedef struct packed {
    logic [31:0] pc; logic [4:0] rd; logic wen; logic [31:0] wd; logic [7:0] excp;
  } res_t;
  typedef struct packed {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
  } req_t;

  res_t exp_res[$];
  req_t exp_req[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // bus responder configuration
  int          cfg_delay = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  logic        cfg_drop  = 1'b0;

  localparam logic [4:0] I_ALU = 5'b00000;
  localparam logic [4:0] I_LB  = 5'b00001;
  localparam logic [4:0] I_LBU = 5'b10001;
  localparam logic [4:0] I_LW  = 5'b01001;
  localparam logic [4:0] I_SH  = 5'b00110;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Result monitor: compares every cycle the stage presents a result, pops on WB handshake.
  initial begin
    res_t act;
    forever begin
      @(negedge clk); #2;
      if (!rst && mem_valid_o) begin
        act = {mem_pc_o, mem_rd_idx_o, mem_rd_wen_o, mem_rd_wdata_o, mem_excp_o};
        if (exp_res.size() == 0) bound_fail("unexpected_result");
        else begin
          chk("result", act, exp_res[0]);
          if (wb_ready_i) void'(exp_res.pop_front());
        end
      end
    end
  end

  // Bus request monitor: request must match (and stay stable) until accepted.
  initial begin
    req_t act;
    forever begin
      @(negedge clk); #2;
      if (!rst && dbus_req_valid_o) begin
        act = {dbus_req_we_o, dbus_req_addr_o, dbus_req_wdata_o, dbus_req_wstrb_o};
        if (exp_req.size() == 0) bound_fail("unexpected_dbus_req");
        else begin
          if (!exp_req[0].we) act.wdata = '0;
          chk("dbus_req", act, exp_req[0]);
          if (dbus_req_ready_i) void'(exp_req.pop_front());
        end
      end
    end
  end

  // Bus slave model: accepts after cfg_delay cycles, responds the following cycle.
  initial begin
    dbus_req_ready_i = 1'b0; dbus_rsp_valid_i = 1'b0;
    dbus_rsp_rdata_i = '0;   dbus_rsp_err_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && dbus_req_valid_o) begin
        repeat (cfg_delay) @(negedge clk);
        dbus_req_ready_i = 1'b1;
        @(negedge clk);
        dbus_req_ready_i = 1'b0;
        if (!cfg_drop) begin
          dbus_rsp_valid_i = 1'b1;
          dbus_rsp_rdata_i = cfg_rdata;
          dbus_rsp_err_i   = cfg_err;
          @(negedge clk);
          dbus_rsp_valid_i = 1'b0;
          dbus_rsp_err_i   = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] info, input logic [4:0] rd, input logic wen,
                       input logic [5:0] excp);
    int n;
    n = 0;
    @(negedge clk);
    ex_pc_i = pc; ex_alu_res_i = alu; ex_rs2_rdata_i = rs2;
    ex_ld_st_info_i = info; ex_rd_idx_i = rd; ex_rd_wen_i = wen; ex_excp_i = excp;
    ex_valid_i = 1'b1;
    #1;
    while (!mem_ready_o && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) bound_fail("accept");
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_res.size() != 0 || exp_req.size() != 0 || mem_valid_o || !mem_ready_o) && n < 200) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 200) bound_fail("drain");
  endtask

  initial begin
    int n;
    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_req_valid", dbus_req_valid_o, 0);
    chk("rst_ready", mem_ready_o, 1);
    rst = 1'b0;
    wb_ready_i = 1'b1;

    // ALU op: result one cycle after accept, no bus access
    exp_res.push_back('{32'h1000, 5'd5, 1'b1, 32'h1234, 8'h00});
    issue(32'h1000, 32'h1234, 32'h0, I_ALU, 5'd5, 1'b1, 6'h0);
    @(negedge clk); #1;
    chk("alu_latency", mem_valid_o, 1);
    chk("alu_no_req", dbus_req_valid_o, 0);
    drain();

    // LB / LBU from byte 3 of 0x80AABBCC
    cfg_rdata = 32'h80AABBCC; cfg_delay = 0;
    exp_req.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    exp_res.push_back('{32'h1004, 5'd6, 1'b1, 32'hFFFFFF80, 8'h00});
    issue(32'h1004, 32'h103, 32'h0, I_LB, 5'd6, 1'b1, 6'h0);
    drain();
    exp_req.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    exp_res.push_back('{32'h1008, 5'd6, 1'b1, 32'h00000080, 8'h00});
    issue(32'h1008, 32'h103, 32'h0, I_LBU, 5'd6, 1'b1, 6'h0);
    drain();

    // SH to upper half, slave stalls 3 cycles: request must hold
    cfg_delay = 3; cfg_rdata = '0;
    exp_req.push_back('{1'b1, 32'h200, 32'hBEEFBEEF, 4'hC});
    exp_res.push_back('{32'h100C, 5'd0, 1'b0, 32'h202, 8'h00});
    issue(32'h100C, 32'h202, 32'h0000BEEF, I_SH, 5'd0, 1'b0, 6'h0);
    drain();
    cfg_delay = 0;

    // misaligned LW: no bus, misalign flag, rd_wen suppressed, latency 1
    exp_res.push_back('{32'h1010, 5'd7, 1'b0, 32'h102, 8'h40});
    issue(32'h1010, 32'h102, 32'h0, I_LW, 5'd7, 1'b1, 6'h0);
    @(negedge clk); #1;
    chk("misalign_latency", mem_valid_o, 1);
    drain();

    // upstream exception on a load: no bus, flags pass through
    exp_res.push_back('{32'h1014, 5'd3, 1'b1, 32'h400, 8'h04});
    issue(32'h1014, 32'h400, 32'h0, I_LW, 5'd3, 1'b1, 6'h04);
    drain();

    // LW with bus error, WB stalled while EX offers the next instruction
    wb_ready_i = 1'b0; cfg_err = 1'b1; cfg_rdata = 32'hDEADBEEF;
    exp_req.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
    exp_res.push_back('{32'h1020, 5'd8, 1'b0, 32'hDEADBEEF, 8'h80});
    issue(32'h1020, 32'h300, 32'h0, I_LW, 5'd8, 1'b1, 6'h0);
    @(negedge clk);
    ex_pc_i = 32'h1024; ex_alu_res_i = 32'h55; ex_rs2_rdata_i = '0;
    ex_ld_st_info_i = I_ALU; ex_rd_idx_i = 5'd9; ex_rd_wen_i = 1'b1; ex_excp_i = '0;
    ex_valid_i = 1'b1;
    #1;
    n = 0;
    while (!mem_valid_o && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) bound_fail("buserr_result");
    cfg_err = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("stall_ready", mem_ready_o, 0);
    end
    // release WB: hand-off and next accept share one edge
    exp_res.push_back('{32'h1024, 5'd9, 1'b1, 32'h55, 8'h00});
    wb_ready_i = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    @(negedge clk); #1;
    chk("b2b_valid", mem_valid_o, 1);
    drain();

    // reset while waiting for a response
    cfg_drop = 1'b1;
    exp_req.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
    issue(32'h1028, 32'h500, 32'h0, I_LW, 5'd10, 1'b1, 6'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("wait_valid", mem_valid_o, 0);
    chk("wait_ready", mem_ready_o, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid", mem_valid_o, 0);
    chk("midrst_ready", mem_ready_o, 1);
    chk("midrst_req", dbus_req_valid_o, 0);
    rst = 1'b0;
    cfg_drop = 1'b0;

    // stage recovers after reset
    exp_res.push_back('{32'h1030, 5'd11, 1'b1, 32'hCAFE, 8'h00});
    issue(32'h1030, 32'hCAFE, 32'h0, I_ALU, 5'd11, 1'b1, 6'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
